// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, baud divisor helper, escape default.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Default escape byte used by the upstream TX escape stage.
  localparam logic [7:0] ESC_DEFAULT = 8'h7D;

  function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and serial line between the TX escape stage and the UART serializer.
interface uart_tx_if;
  logic       TX_READY_O;
  logic [7:0] DATA_SEND_I;
  logic       WRITE_I;
  logic       TX_O;

  modport master (input TX_READY_O, input TX_O, output DATA_SEND_I, output WRITE_I);
  modport slave  (output TX_READY_O, output TX_O, input DATA_SEND_I, input WRITE_I);
endinterface

// File: rtl/uart_tx_baud_tick.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count for one cycle.
module baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic i_clear,
  output logic o_tick
);

  localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] TC = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK_I) begin
    if (RST_I || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == TC) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == TC);

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer, 8 data bits LSB first, 1 stop bit.
// Define UART_TX_PARITY_EN to insert an even parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_RATE  = 100_000_000,
  parameter int BAUD_RATE = 3_000_000
) (
  input  logic      CLK_I,
  input  logic      RST_I,
  uart_tx_if.slave  bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx: CLK_RATE/BAUD_RATE must be at least 2");
    end
  endgenerate

  localparam logic [2:0] S_IDLE   = TX_IDLE;
  localparam logic [2:0] S_START  = TX_START;
  localparam logic [2:0] S_DATA   = TX_DATA;
  localparam logic [2:0] S_STOP   = TX_STOP;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = TX_PARITY;
`endif

  logic [2:0] r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_tx;
  logic       r_ready;
`ifdef UART_TX_PARITY_EN
  logic       r_parity;
`endif

  logic w_accept;
  logic w_tick;

  assign w_accept = (r_state == S_IDLE) && bus.WRITE_I;

  baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .i_clear (w_accept),
    .o_tick  (w_tick)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= bus.DATA_SEND_I;
            r_ready <= 1'b0;
            r_tx    <= 1'b0;
            r_state <= S_START;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^bus.DATA_SEND_I;
`endif
          end
        end
        S_START: begin
          // Line value is registered one bit ahead, so the shift happens as the bit goes out.
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.TX_O       = r_tx;
  assign bus.TX_READY_O = r_ready;

endmodule
